// File: rtl/usb_crc5_pkg.sv
// Shared USB token constants and the nibble-wide CRC5 update used by both the
// transmit generator and the token receiver.
package usb_crc5_pkg;

  localparam logic [4:0] CRC5_INIT     = 5'h1F;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PID,
    ST_BODY,
    ST_DONE
  } tok_state_e;

  // Four serial LFSR steps, data_in[3] is the earliest bit on the wire.
  function automatic logic [4:0] crc5_nibble(input logic [4:0] crc, input logic [3:0] nibble);
    logic [4:0] c;
    logic       d;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      d = nibble[i];
      c = {c[3], c[2], c[1] ^ c[4] ^ d, c[0], c[4] ^ d};
    end
    return c;
  endfunction

  // Nibble arrives earliest-bit-in-msb; fields are stored LSB-first.
  function automatic logic [3:0] rev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic is_token_pid(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) || (pid == PID_SETUP);
  endfunction

endpackage

// File: rtl/usb_token_rx_crc5_if.sv
// Nibble input stream and decoded-token result bus of the token receiver.
interface usb_token_rx_crc5_if;
  logic       in_valid;
  logic       in_sop;
  logic [3:0] data_in;
  logic       tok_valid;
  logic [3:0] tok_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       crc_err;
  logic       pid_err;
  logic       abort;

  modport master (
    output in_valid, in_sop, data_in,
    input  tok_valid, tok_pid, tok_addr, tok_endp, crc_err, pid_err, abort
  );

  modport slave (
    input  in_valid, in_sop, data_in,
    output tok_valid, tok_pid, tok_addr, tok_endp, crc_err, pid_err, abort
  );
endinterface

// File: rtl/usb_token_rx_crc5.sv
// USB token receiver: rebuilds PID/addr/endp from a 4-bit/clk stream, checks
// the PID complement and CRC5 residual, and reports one result per packet.
import usb_crc5_pkg::*;

module usb_token_rx_crc5 #(
  parameter int GAP_MAX = 15
) (
  input logic                clk,
  input logic                rst,
  usb_token_rx_crc5_if.slave bus
);

  tok_state_e  state, state_nxt;
  logic [2:0]  nib_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  crc;
  logic [7:0]  pid_r;
  logic [10:0] body_sr;

  logic        sop, gap_to;
  logic        start, pid_done, body_acc, last, abort_set;
  logic [3:0]  nib_r;
  logic [4:0]  crc_nxt;

  assign sop     = bus.in_valid & bus.in_sop;
  assign gap_to  = (gap_cnt == 8'(GAP_MAX - 1));
  assign nib_r   = rev4(bus.data_in);
  assign crc_nxt = crc5_nibble(crc, bus.data_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A sop nibble always restarts a packet; mid-packet it also drops the old one.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pid_done  = 1'b0;
    body_acc  = 1'b0;
    last      = 1'b0;
    abort_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sop) begin
          start     = 1'b1;
          state_nxt = ST_PID;
        end
      end
      ST_PID, ST_BODY: begin
        if (sop) begin
          abort_set = 1'b1;
          start     = 1'b1;
          state_nxt = ST_PID;
        end else if (bus.in_valid) begin
          if (state == ST_PID) begin
            pid_done  = 1'b1;
            state_nxt = ST_BODY;
          end else begin
            body_acc = 1'b1;
            if (nib_cnt == 3'd5) begin
              last      = 1'b1;
              state_nxt = ST_DONE;
            end
          end
        end else if (gap_to) begin
          abort_set = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (sop) begin
          start     = 1'b1;
          state_nxt = ST_PID;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_cnt       <= 3'd0;
      gap_cnt       <= 8'd0;
      crc           <= CRC5_INIT;
      pid_r         <= 8'd0;
      body_sr       <= 11'd0;
      bus.tok_valid <= 1'b0;
      bus.tok_pid   <= 4'd0;
      bus.tok_addr  <= 7'd0;
      bus.tok_endp  <= 4'd0;
      bus.crc_err   <= 1'b0;
      bus.pid_err   <= 1'b0;
      bus.abort     <= 1'b0;
    end else begin
      bus.abort     <= abort_set;
      bus.tok_valid <= last;
      bus.crc_err   <= 1'b0;
      bus.pid_err   <= 1'b0;

      // Idle cycles only count while a packet is in flight.
      if (bus.in_valid || abort_set || !(state == ST_PID || state == ST_BODY))
        gap_cnt <= 8'd0;
      else
        gap_cnt <= gap_cnt + 8'd1;

      if (start) begin
        nib_cnt     <= 3'd1;
        pid_r[3:0]  <= nib_r;
      end else if (pid_done) begin
        nib_cnt     <= 3'd2;
        pid_r[7:4]  <= nib_r;
        crc         <= CRC5_INIT;
      end else if (body_acc) begin
        crc     <= crc_nxt;
        nib_cnt <= last ? 3'd0 : nib_cnt + 3'd1;
        // Only addr/endp bits are kept; the CRC field is consumed by the LFSR.
        case (nib_cnt)
          3'd2:    body_sr[3:0]  <= nib_r;
          3'd3:    body_sr[7:4]  <= nib_r;
          3'd4:    body_sr[10:8] <= nib_r[2:0];
          default: ;
        endcase
        if (last) begin
          bus.tok_pid  <= pid_r[3:0];
          bus.tok_addr <= body_sr[6:0];
          bus.tok_endp <= body_sr[10:7];
          bus.crc_err  <= (crc_nxt != CRC5_RESIDUAL);
          bus.pid_err  <= (pid_r[7:4] != ~pid_r[3:0]) || !is_token_pid(pid_r[3:0]);
        end
      end else if (abort_set) begin
        nib_cnt <= 3'd0;
      end
    end
  end

endmodule
